// File: rtl/soc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_pkg
// Description : Shared constants, loader FSM encoding and byte-order helper
//               for the flash boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_pkg;

    // SPI NOR "READ" opcode (no dummy cycles, single continuous read).
    localparam logic [7:0] FLASH_CMD_READ = 8'h03;

    // Loader FSM encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_FINISH = 3'd4
    } loader_state_t;

    // Bytes are shifted in first-byte-first, so the first byte lands in
    // [31:24]; memory wants the first byte in [7:0].
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bit_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_bit_engine
// Description : SPI mode-0 SCK generator. Emits a sample strobe in the clk
//               cycle SCK has just risen and a shift strobe on the edge where
//               SCK falls, so the owner can change MOSI while SCK goes low.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bit_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sck,
    output logic o_sample_tick,
    output logic o_shift_tick
);

    localparam int                 c_CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sck;
    logic               r_sample;
    logic               w_half_done;

    assign w_half_done = (r_cnt == c_CNT_LAST);

    // Half-period divider; SCK parks low whenever the engine is disabled.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt    <= '0;
            r_sck    <= 1'b0;
            r_sample <= 1'b0;
        end else if (w_half_done) begin
            r_cnt    <= '0;
            r_sck    <= ~r_sck;
            r_sample <= ~r_sck;
        end else begin
            r_cnt    <= r_cnt + c_CNT_W'(1);
            r_sample <= 1'b0;
        end
    end

    assign o_sck         = r_sck;
    assign o_sample_tick = r_sample;
    assign o_shift_tick  = i_en & w_half_done & r_sck;

endmodule
`default_nettype wire

// File: rtl/flash_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : flash_boot_loader
// Description : Boot-time copier. Issues one continuous SPI READ at
//               FLASH_BASE and writes WORD_COUNT little-endian 32-bit words
//               to memory starting at word address 0.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_boot_loader
    import soc_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = 24'h100000,
    parameter int          WORD_COUNT = 4096,
    parameter int          CLK_DIV    = 2,
    parameter int          ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flashMiso,
    output logic              flashClk,
    output logic              flashMosi,
    output logic              flashCs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done
);

    localparam int              c_WN    = ADDR_W + 1;
    localparam logic [c_WN-1:0] c_WORDS = c_WN'(WORD_COUNT);

    loader_state_t     r_state_q, w_state_d;
    logic [5:0]        r_bit_q,   w_bit_d;
    logic [c_WN-1:0]   r_word_q,  w_word_d;
    logic [31:0]       r_tx_q,    w_tx_d;
    logic [31:0]       r_rx_q,    w_rx_d;
    logic              r_we_q,    w_we_d;
    logic [ADDR_W-1:0] r_addr_q,  w_addr_d;
    logic [31:0]       r_wdata_q, w_wdata_d;
    logic              r_cs_q,    w_cs_d;
    logic              r_busy_q,  w_busy_d;
    logic              r_done_q,  w_done_d;

    logic w_en, w_finish, w_sample_tick, w_shift_tick;

    // The last write has been issued: stop SCK on the same edge CS rises.
    assign w_finish = (r_state_q == ST_DATA) && r_we_q && (r_word_q == c_WORDS);
    assign w_en     = ((r_state_q == ST_CMD) || (r_state_q == ST_ADDR) ||
                       (r_state_q == ST_DATA)) && !w_finish;

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk           (clk),
        .rst           (reset),
        .i_en          (w_en),
        .o_sck         (flashClk),
        .o_sample_tick (w_sample_tick),
        .o_shift_tick  (w_shift_tick)
    );

    // Next-state logic: phase sequencing, bit/word counting, word assembly.
    always_comb begin
        w_state_d = r_state_q;
        w_bit_d   = r_bit_q;
        w_word_d  = r_word_q;
        w_tx_d    = r_tx_q;
        w_rx_d    = r_rx_q;
        w_we_d    = 1'b0;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_cs_d    = r_cs_q;
        w_busy_d  = r_busy_q;
        w_done_d  = r_done_q;

        // Command/address bits drain out MSB first; zeros follow in DATA.
        if (w_shift_tick) begin
            w_tx_d = {r_tx_q[30:0], 1'b0};
        end

        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_state_d = ST_CMD;
                    w_cs_d    = 1'b0;
                    w_busy_d  = 1'b1;
                    w_done_d  = 1'b0;
                    w_bit_d   = '0;
                    w_word_d  = '0;
                    w_rx_d    = '0;
                    w_tx_d    = {FLASH_CMD_READ, FLASH_BASE};
                end
            end
            ST_CMD: begin
                if (w_sample_tick) begin
                    if (r_bit_q == 6'd7) begin
                        w_state_d = ST_ADDR;
                        w_bit_d   = '0;
                    end else begin
                        w_bit_d = r_bit_q + 6'd1;
                    end
                end
            end
            ST_ADDR: begin
                if (w_sample_tick) begin
                    if (r_bit_q == 6'd23) begin
                        w_state_d = ST_DATA;
                        w_bit_d   = '0;
                    end else begin
                        w_bit_d = r_bit_q + 6'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_finish) begin
                    w_state_d = ST_FINISH;
                    w_cs_d    = 1'b1;
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                end else if (w_sample_tick) begin
                    w_rx_d = {r_rx_q[30:0], flashMiso};
                    if (r_bit_q == 6'd31) begin
                        w_we_d    = 1'b1;
                        w_addr_d  = r_word_q[ADDR_W-1:0];
                        w_wdata_d = bswap32(w_rx_d);
                        w_word_d  = r_word_q + c_WN'(1);
                        w_bit_d   = '0;
                    end else begin
                        w_bit_d = r_bit_q + 6'd1;
                    end
                end
            end
            ST_FINISH: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_bit_q   <= '0;
            r_word_q  <= '0;
            r_tx_q    <= '0;
            r_rx_q    <= '0;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_cs_q    <= 1'b1;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_bit_q   <= w_bit_d;
            r_word_q  <= w_word_d;
            r_tx_q    <= w_tx_d;
            r_rx_q    <= w_rx_d;
            r_we_q    <= w_we_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_cs_q    <= w_cs_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign flashMosi = r_tx_q[31];
    assign flashCs   = r_cs_q;
    assign mem_we    = r_we_q;
    assign mem_addr  = r_addr_q;
    assign mem_wdata = r_wdata_q;
    assign busy      = r_busy_q;
    assign done      = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_boot_loader
// Description : Scoreboard bench for flash_boot_loader. Two DUTs (CLK_DIV 2
//               and 1), each with a behavioural SPI NOR model; expected
//               writes are queued at start and popped by a write monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_boot_loader;

    localparam logic [23:0] BASE = 24'h100000;
    localparam int          WC   = 4;
    localparam int          AW   = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset0, start0, miso0, sck0, mosi0, cs0, we0, busy0, done0;
    logic [AW-1:0] addr0;
    logic [31:0]   wdata0;
    logic          reset1, start1, miso1, sck1, mosi1, cs1, we1, busy1, done1;
    logic [AW-1:0] addr1;
    logic [31:0]   wdata1;

    flash_boot_loader #(.FLASH_BASE(BASE), .WORD_COUNT(WC), .CLK_DIV(2), .ADDR_W(AW)) u_dut0 (
        .clk(clk), .reset(reset0), .start(start0), .flashMiso(miso0),
        .flashClk(sck0), .flashMosi(mosi0), .flashCs(cs0),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0), .busy(busy0), .done(done0));

    flash_boot_loader #(.FLASH_BASE(BASE), .WORD_COUNT(WC), .CLK_DIV(1), .ADDR_W(AW)) u_dut1 (
        .clk(clk), .reset(reset1), .start(start1), .flashMiso(miso1),
        .flashClk(sck1), .flashMosi(mosi1), .flashCs(cs1),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .busy(busy1), .done(done1));

    typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
    wr_t q0[$];
    wr_t q1[$];

    int         errors = 0;
    int         checks = 0;
    int         wr0 = 0;
    int         wr1 = 0;
    logic       rand_mode = 1'b0;
    logic [7:0] rmem [256];

    // Flash content: byte = addr[7:0], or a random image when rand_mode is set.
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return rand_mode ? rmem[a[7:0]] : a[7:0];
    endfunction

    function automatic logic fbit(input logic [23:0] a, input int b);
        logic [7:0] by;
        by = fbyte(a + 24'(b / 8));
        return by[7 - (b % 8)];
    endfunction

    // Flash model 0: header captured at SCK rises, data shifted out on falls.
    int          fn0 = 0;
    int          fbad0 = 0;
    logic [31:0] fhdr0 = '0;
    initial miso0 = 1'b0;
    always @(posedge cs0 or posedge sck0 or negedge sck0) begin
        if (cs0) fn0 = 0;
        else if (sck0) begin
            if (fn0 == 0) fbad0 = 0;
            if (fn0 < 32) fhdr0 = {fhdr0[30:0], mosi0};
            else if (mosi0) fbad0++;
            fn0++;
        end else if (fn0 >= 32) miso0 <= fbit(fhdr0[23:0], fn0 - 32);
    end

    // Flash model 1.
    int          fn1 = 0;
    int          fbad1 = 0;
    logic [31:0] fhdr1 = '0;
    initial miso1 = 1'b0;
    always @(posedge cs1 or posedge sck1 or negedge sck1) begin
        if (cs1) fn1 = 0;
        else if (sck1) begin
            if (fn1 == 0) fbad1 = 0;
            if (fn1 < 32) fhdr1 = {fhdr1[30:0], mosi1};
            else if (mosi1) fbad1++;
            fn1++;
        end else if (fn1 >= 32) miso1 <= fbit(fhdr1[23:0], fn1 - 32);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 1) start1 = v; else start0 = v;
    endtask

    // Reference model: word k is flash bytes BASE+4k..BASE+4k+3, little-endian.
    task automatic push_expected(input int d);
        wr_t         e;
        logic [23:0] a;
        for (int k = 0; k < WC; k++) begin
            a   = BASE + 24'(4 * k);
            e.a = AW'(k);
            e.d = {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
            if (d == 1) q1.push_back(e); else q0.push_back(e);
        end
    endtask

    // Write monitor: every mem_we must match the head of that DUT's queue.
    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (we0) begin
                wr0++;
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL write0: unexpected write addr=%0d data=0x%0h", addr0, wdata0);
                end else begin
                    e = q0.pop_front();
                    check("write0", {20'h0, addr0, wdata0}, {20'h0, e.a, e.d});
                end
            end
            if (we1) begin
                wr1++;
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL write1: unexpected write addr=%0d data=0x%0h", addr1, wdata1);
                end else begin
                    e = q1.pop_front();
                    check("write1", {20'h0, addr1, wdata1}, {20'h0, e.a, e.d});
                end
            end
        end
    endtask

    task automatic run_copy(input int d, input bit mid_start, input bit chk_len);
        int cs_low = 0, last_we = -100, done_i = -1, ws, mid_at;
        ws     = (d == 1) ? wr1 : wr0;
        mid_at = (d == 1) ? $urandom_range(20, 300) : $urandom_range(20, 600);
        @(negedge clk);
        push_expected(d);
        set_start(d, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            set_start(d, mid_start && (i == mid_at));
            if (i == 0) begin
                check("busy_after_start", (d == 1) ? busy1 : busy0, 1);
                check("done_cleared", (d == 1) ? done1 : done0, 0);
            end
            if (((d == 1) ? cs1 : cs0) == 1'b0) cs_low++;
            if ((d == 1) ? we1 : we0) last_we = i;
            if ((d == 1) ? done1 : done0) begin
                done_i = i;
                break;
            end
        end
        check("done_seen", (done_i >= 0), 1);
        check("done_after_last_we", 64'(done_i - last_we), 1);
        check("busy_at_done", (d == 1) ? busy1 : busy0, 0);
        check("cs_high_at_done", (d == 1) ? cs1 : cs0, 1);
        if (chk_len) check("cs_low_clks", 64'(cs_low), 640);
        check("write_count", 64'(((d == 1) ? wr1 : wr0) - ws), WC);
        check("queue_empty", 64'((d == 1) ? q1.size() : q0.size()), 0);
        check("cmd_addr", (d == 1) ? fhdr1 : fhdr0, {8'h03, BASE});
        check("mosi_zero_in_data", 64'((d == 1) ? fbad1 : fbad0), 0);
        repeat ($urandom_range(1, 6)) @(negedge clk);
    endtask

    task automatic reset_mid();
        int found = 0;
        @(negedge clk);
        push_expected(0);
        start0 = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (we0 && addr0 == AW'(1)) begin
                found = 1;
                break;
            end
        end
        check("word1_reached", found, 1);
        #1;
        reset0 = 1'b1;
        q0.delete();
        @(negedge clk);
        check("rst_cs", cs0, 1);
        check("rst_we_busy_done_sck", {we0, busy0, done0, sck0}, 0);
        reset0 = 1'b0;
    endtask

    task automatic randomize_flash();
        for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom);
    endtask

    initial begin
        reset0 = 1'b1; reset1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check("reset_state0", {sck0, cs0, mosi0, we0, busy0, done0, addr0, wdata0}, {6'b010000, 44'h0});
        check("reset_state1", {sck1, cs1, mosi1, we1, busy1, done1, addr1, wdata1}, {6'b010000, 44'h0});
        reset0 = 1'b0; reset1 = 1'b0;
        @(negedge clk);

        run_copy(0, 1'b0, 1'b1);
        run_copy(0, 1'b1, 1'b1);
        randomize_flash();
        rand_mode = 1'b1;
        run_copy(0, 1'b1, 1'b1);
        rand_mode = 1'b0;
        reset_mid();
        run_copy(0, 1'b0, 1'b1);

        run_copy(1, 1'b0, 1'b0);
        randomize_flash();
        rand_mode = 1'b1;
        run_copy(1, 1'b1, 1'b0);
        rand_mode = 1'b0;

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
